// File: rtl/stream_serializer.sv
// Parallel-to-serial front end: accepts words over valid/ready and shifts them out one bit per clock.
// A one-word holding buffer keeps back-to-back words contiguous on stream_out.
module stream_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic                  stream_out,
    output logic                  stream_valid,
    output logic                  last_bit
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  accept;
    logic                  at_last;
    logic [DATA_WIDTH-1:0] sh_shifted;

    // Ready is only ever blocked by a full hold buffer, so the upstream path has no combinational
    // dependency on the shifter itself.
    assign data_ready = rst && !hold_full_q;
    assign accept     = data_valid && data_ready;
    assign at_last    = (state_q == SHIFT) && (cnt_q == LAST_CNT);
    assign sh_shifted = MSB_FIRST ? (sh_q << 1) : (sh_q >> 1);

    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    sh_d    = data_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sh_d  = sh_shifted;
                cnt_d = cnt_q + 1'b1;
                if (accept && !at_last) begin
                    hold_d      = data_in;
                    hold_full_d = 1'b1;
                end
                // On the final bit a held word wins; otherwise an incoming word skips the hold buffer.
                if (at_last) begin
                    cnt_d = '0;
                    if (hold_full_q) begin
                        sh_d        = hold_q;
                        hold_full_d = 1'b0;
                    end else if (accept) begin
                        sh_d = data_in;
                    end else begin
                        sh_d    = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
        end
    end

    // The shift register is zeroed whenever the block returns to idle, so its output bit is 0 there.
    assign stream_out   = MSB_FIRST ? sh_q[DATA_WIDTH-1] : sh_q[0];
    assign stream_valid = (state_q == SHIFT);
    assign last_bit     = at_last;

endmodule

// File: tb/tb_stream_serializer.sv
// Self-checking bench for stream_serializer: an MSB-first and an LSB-first instance share the same
// upstream, and both are compared each cycle against a word-queue model of the serial stream.
module tb_stream_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] dataIn = '0;
    logic         dataValid = 1'b0;

    logic readyM, outM, validM, lastM;
    logic readyL, outL, validL, lastL;

    wire [7:0] observed = {outM, validM, lastM, readyM, outL, validL, lastL, readyL};

    int testsRun    = 0;
    int testsFailed = 0;

    // Model: queue of words awaiting or in transmission; head word is currently on the wire at bitIdx.
    logic [W-1:0] wordQ[$];
    int           bitIdx = 0;

    stream_serializer #(.DATA_WIDTH(W), .MSB_FIRST(1'b1)) dutMsb (
        .clk(clk), .rst(rst), .data_in(dataIn), .data_valid(dataValid),
        .data_ready(readyM), .stream_out(outM), .stream_valid(validM), .last_bit(lastM)
    );

    stream_serializer #(.DATA_WIDTH(W), .MSB_FIRST(1'b0)) dutLsb (
        .clk(clk), .rst(rst), .data_in(dataIn), .data_valid(dataValid),
        .data_ready(readyL), .stream_out(outL), .stream_valid(validL), .last_bit(lastL)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic modelReady();
        return rst && (wordQ.size() <= 1);
    endfunction

    function automatic logic [7:0] expectedOutputs();
        logic v, last, bm, bl, rdy;
        logic [W-1:0] head;
        v    = (wordQ.size() > 0);
        head = v ? wordQ[0] : '0;
        bm   = v ? head[W-1-bitIdx] : 1'b0;
        bl   = v ? head[bitIdx] : 1'b0;
        last = v && (bitIdx == W - 1);
        rdy  = modelReady();
        return {bm, v, last, rdy, bl, v, last, rdy};
    endfunction

    task automatic stepClock(output logic accepted);
        accepted = dataValid && modelReady();
        @(posedge clk);
        if (!rst) begin
            wordQ.delete();
            bitIdx   = 0;
            accepted = 1'b0;
        end else begin
            if (wordQ.size() > 0) begin
                bitIdx++;
                if (bitIdx == W) begin
                    void'(wordQ.pop_front());
                    bitIdx = 0;
                end
            end
            if (accepted) wordQ.push_back(dataIn);
        end
        #1;
    endtask

    task automatic test_reset();
        logic acc;
        logic [7:0] exp;
        #1;
        testsRun++;
        if (observed !== 8'h00) begin
            testsFailed++;
            $display("[TB] FAIL reset_initial: got %b expected %b", observed, 8'h00);
        end
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b1;
        #1;
        testsRun++;
        if (observed !== 8'b0001_0001) begin
            testsFailed++;
            $display("[TB] FAIL reset_release: got %b expected %b", observed, 8'b0001_0001);
        end
        for (int i = 0; i < 3; i++) begin
            stepClock(acc);
            testsRun++;
            exp = expectedOutputs();
            if (observed !== exp) begin
                testsFailed++;
                $display("[TB] FAIL reset_idle cycle %0d: got %b expected %b", i, observed, exp);
            end
        end
        dataIn = 8'hE7; dataValid = 1'b1;
        stepClock(acc);
        dataValid = 1'b0;
        stepClock(acc);
        stepClock(acc);
        rst = 1'b0;
        wordQ.delete(); bitIdx = 0;
        #1;
        testsRun++;
        if (observed !== 8'h00) begin
            testsFailed++;
            $display("[TB] FAIL reset_async: got %b expected %b", observed, 8'h00);
        end
        stepClock(acc);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            stepClock(acc);
            testsRun++;
            exp = expectedOutputs();
            if (observed !== exp || outM !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL reset_after cycle %0d: got %b expected %b", i, observed, exp);
            end
        end
    endtask

    task automatic test_single();
        logic acc;
        logic [7:0] exp;
        logic [7:0] pattern;
        pattern = 8'b1101_0000;
        dataIn = 8'hD0; dataValid = 1'b1;
        stepClock(acc);
        dataValid = 1'b0;
        for (int i = 0; i < W; i++) begin
            testsRun++;
            exp = expectedOutputs();
            if ({outM, validM, lastM} !== {pattern[7-i], 1'b1, (i == W - 1)} || observed !== exp) begin
                testsFailed++;
                $display("[TB] FAIL single_D0 bit %0d: got %b expected %b (msb bit %b)",
                         i, observed, exp, pattern[7-i]);
            end
            stepClock(acc);
        end
        testsRun++;
        if (validM !== 1'b0 || outM !== 1'b0 || lastM !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL single_end: got out/valid/last %b%b%b expected 000", outM, validM, lastM);
        end
    endtask

    task automatic test_back_to_back();
        logic acc;
        logic [7:0] exp;
        logic [W-1:0] words[3];
        logic [3*W-1:0] got;
        int k, nBits, firstValid, lastValid;
        words[0] = 8'hFF; words[1] = 8'h00; words[2] = 8'hA5;
        k = 0; nBits = 0; got = '0; firstValid = -1; lastValid = -1;
        dataIn = words[0]; dataValid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            stepClock(acc);
            if (acc) begin
                k++;
                if (k < 3) dataIn = words[k];
                else dataValid = 1'b0;
            end
            testsRun++;
            exp = expectedOutputs();
            if (observed !== exp) begin
                testsFailed++;
                $display("[TB] FAIL back_to_back cycle %0d: got %b expected %b", c, observed, exp);
            end
            if (validM === 1'b1 && nBits < 3 * W) begin
                got = {got[3*W-2:0], outM};
                nBits++;
                if (firstValid < 0) firstValid = c;
                lastValid = c;
            end
        end
        testsRun++;
        if (got !== 24'hFF00A5 || nBits != 24 || (lastValid - firstValid) != 23) begin
            testsFailed++;
            $display("[TB] FAIL back_to_back_stream: got %h (%0d bits, span %0d) expected ff00a5 (24 bits, span 23)",
                     got, nBits, lastValid - firstValid);
        end
    endtask

    task automatic test_lsb_first();
        logic acc;
        logic [7:0] exp;
        logic [7:0] pattern;
        pattern = 8'b1101_0000;
        dataIn = 8'h0B; dataValid = 1'b1;
        stepClock(acc);
        dataValid = 1'b0;
        for (int i = 0; i < W; i++) begin
            testsRun++;
            exp = expectedOutputs();
            if (outL !== pattern[7-i] || validL !== 1'b1 || observed !== exp) begin
                testsFailed++;
                $display("[TB] FAIL lsb_first_0B bit %0d: got %b expected %b (lsb bit %b)",
                         i, observed, exp, pattern[7-i]);
            end
            stepClock(acc);
        end
    endtask

    task automatic test_backpressure();
        logic acc;
        logic [7:0] exp;
        logic [W-1:0] words[3];
        logic [3*W-1:0] got;
        int k, nBits;
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        k = 0; nBits = 0; got = '0;
        dataIn = words[0]; dataValid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            stepClock(acc);
            if (acc) k++;
            if (k >= 3) dataValid = 1'b0;
            else if (modelReady()) dataIn = words[k];
            else dataIn = W'($urandom);
            testsRun++;
            exp = expectedOutputs();
            if (observed !== exp) begin
                testsFailed++;
                $display("[TB] FAIL backpressure cycle %0d: got %b expected %b", c, observed, exp);
            end
            if (validM === 1'b1 && nBits < 3 * W) begin
                got = {got[3*W-2:0], outM};
                nBits++;
            end
        end
        dataValid = 1'b0;
        testsRun++;
        if (got !== 24'h112233 || nBits != 24) begin
            testsFailed++;
            $display("[TB] FAIL backpressure_stream: got %h (%0d bits) expected 112233 (24 bits)", got, nBits);
        end
    endtask

    task automatic test_reset_midword();
        logic acc;
        logic [7:0] exp;
        logic [W-1:0] got;
        int guard;
        dataIn = 8'h5A; dataValid = 1'b1;
        stepClock(acc);
        dataIn = 8'h96;
        stepClock(acc);
        dataValid = 1'b0;
        guard = 0;
        while (bitIdx != 3 && guard < 20) begin
            stepClock(acc);
            guard++;
        end
        testsRun++;
        if (wordQ.size() != 2 || readyM !== 1'b0 || validM !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL midword_setup: got ready %b valid %b expected ready 0 valid 1", readyM, validM);
        end
        rst = 1'b0;
        wordQ.delete(); bitIdx = 0;
        #1;
        testsRun++;
        if (observed !== 8'h00) begin
            testsFailed++;
            $display("[TB] FAIL midword_reset: got %b expected %b", observed, 8'h00);
        end
        stepClock(acc);
        rst = 1'b1;
        stepClock(acc);
        dataIn = 8'hC3; dataValid = 1'b1;
        stepClock(acc);
        dataValid = 1'b0;
        got = '0;
        for (int i = 0; i < W + 4; i++) begin
            testsRun++;
            exp = expectedOutputs();
            if (observed !== exp) begin
                testsFailed++;
                $display("[TB] FAIL midword_after cycle %0d: got %b expected %b", i, observed, exp);
            end
            if (i < W) got = {got[W-2:0], outM};
            stepClock(acc);
        end
        testsRun++;
        if (got !== 8'hC3) begin
            testsFailed++;
            $display("[TB] FAIL midword_C3: got %h expected c3", got);
        end
    endtask

    task automatic test_random();
        logic acc;
        logic [7:0] exp;
        dataValid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            stepClock(acc);
            if (acc || !dataValid) begin
                dataValid = ($urandom_range(0, 3) != 0);
                dataIn    = W'($urandom);
            end
            testsRun++;
            exp = expectedOutputs();
            if (observed !== exp) begin
                testsFailed++;
                $display("[TB] FAIL random cycle %0d: got %b expected %b", c, observed, exp);
            end
        end
        dataValid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_lsb_first();
        test_backpressure();
        test_reset_midword();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
